// File: rtl/pipe_stage_reg.sv
// Two-slot skid-buffered pipeline register with flush, bubble gating
// and saturating bubble/stall counters.
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 64,
  parameter int DEST_W    = 5,
  parameter int CTRL_W    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] payload_in,
  input  logic [DEST_W-1:0]    dest_in,
  input  logic [CTRL_W-1:0]    ctrl_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic [DEST_W-1:0]    dest_out,
  output logic [CTRL_W-1:0]    ctrl_out,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                 main_valid;
  logic [PAYLOAD_W-1:0] main_payload;
  logic [DEST_W-1:0]    main_dest;
  logic [CTRL_W-1:0]    main_ctrl;

  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_payload;
  logic [DEST_W-1:0]    skid_dest;
  logic [CTRL_W-1:0]    skid_ctrl;

  logic accept;
  logic release_beat;
  logic main_open;
  logic ld_skid;
  logic ld_in;
  logic sk_wr;
  logic main_valid_n;
  logic skid_valid_n;

  // in_ready comes straight off the skid valid flop
  assign in_ready     = ~skid_valid;
  assign out_valid    = main_valid;
  assign payload_out  = main_payload;
  assign dest_out     = main_dest;
  assign ctrl_out     = main_valid ? main_ctrl : '0;

  assign accept       = in_valid & in_ready;
  assign release_beat = main_valid & out_ready;
  assign main_open    = ~main_valid | release_beat;
  assign ld_skid      = main_open & skid_valid;
  assign ld_in        = main_open & ~skid_valid & accept;
  assign sk_wr        = accept & ~ld_in;

  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      if (main_open) begin
        main_valid_n = skid_valid | accept;
      end
      if (ld_skid) begin
        skid_valid_n = sk_wr;
      end else if (sk_wr) begin
        skid_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
    end
  end

  // data slots hold their contents across flush and bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_payload <= '0;
      main_dest    <= '0;
      main_ctrl    <= '0;
    end else if (ld_skid) begin
      main_payload <= skid_payload;
      main_dest    <= skid_dest;
      main_ctrl    <= skid_ctrl;
    end else if (ld_in) begin
      main_payload <= payload_in;
      main_dest    <= dest_in;
      main_ctrl    <= ctrl_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_payload <= '0;
      skid_dest    <= '0;
      skid_ctrl    <= '0;
    end else if (sk_wr) begin
      skid_payload <= payload_in;
      skid_dest    <= dest_in;
      skid_ctrl    <= ctrl_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (out_ready && !main_valid
                 && bubble_cnt != CNT_MAX) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready
                 && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: FIFO order, flush, bubble gating,
// counter saturation and asynchronous reset.
module tb_pipe_stage_reg;

  localparam int PW = 64;
  localparam int DW = 5;
  localparam int CW = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] payload_in;
  logic [DW-1:0] dest_in;
  logic [CW-1:0] ctrl_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] payload_out;
  logic [DW-1:0] dest_out;
  logic [CW-1:0] ctrl_out;
  logic [NW-1:0] bubble_cnt;
  logic [NW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  logic [PW+DW+CW-1:0] q[$];
  logic [PW+DW+CW-1:0] exp_beat;
  logic [NW-1:0] mb = '0;
  logic [NW-1:0] ms = '0;

  pipe_stage_reg #(
    .PAYLOAD_W(PW), .DEST_W(DW), .CTRL_W(CW), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .payload_in(payload_in), .dest_in(dest_in),
    .ctrl_in(ctrl_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .payload_out(payload_out), .dest_out(dest_out),
    .ctrl_out(ctrl_out),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: checks on negedge, then accounts for the coming posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mb = '0;
      ms = '0;
      chk("rst_valid", out_valid, 0);
      chk("rst_ctrl", ctrl_out, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_bub", bubble_cnt, 0);
      chk("rst_stall", stall_cnt, 0);
    end else begin
      chk("bubble_cnt", bubble_cnt, mb);
      chk("stall_cnt", stall_cnt, ms);
      if (!out_valid) chk("ctrl_gate", ctrl_out, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_extra", 1, 0);
        end else begin
          exp_beat = q.pop_front();
          chk("sb_beat", {payload_out, dest_out, ctrl_out}, exp_beat);
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready)
        q.push_back({payload_in, dest_in, ctrl_in});
      if (out_ready && !out_valid && mb != 4'hf) mb = mb + 4'd1;
      if (out_valid && !out_ready && ms != 4'hf) ms = ms + 4'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [PW-1:0] p, input logic [CW-1:0] c);
    in_valid   = 1'b1;
    payload_in = p;
    dest_in    = DW'($urandom);
    ctrl_in    = c;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    payload_in = '0;
    dest_in = '0;
    ctrl_in = '0;
    #3;
    chk("r0_valid", out_valid, 0);
    chk("r0_payload", payload_out, 0);
    chk("r0_dest", dest_out, 0);
    chk("r0_ready", in_ready, 1);
    repeat (2) step();
    rst_n = 1'b1;

    // pass-through
    out_ready = 1'b1;
    drive(64'h11, 4'h3);
    chk("pt_a_valid", out_valid, 1);
    chk("pt_a", payload_out, 64'h11);
    drive(64'h22, 4'h5);
    chk("pt_b", payload_out, 64'h22);
    drive(64'h33, 4'h6);
    chk("pt_c", payload_out, 64'h33);
    in_valid = 1'b0;
    chk("pt_stall", stall_cnt, 0);
    repeat (2) step();

    // backpressure
    out_ready = 1'b0;
    drive(64'hA, 4'h1);
    drive(64'hB, 4'h2);
    in_valid = 1'b0;
    chk("bp_ready", in_ready, 0);
    chk("bp_main", payload_out, 64'hA);
    out_ready = 1'b1;
    step();
    chk("bp_b", payload_out, 64'hB);
    chk("bp_valid", out_valid, 1);
    chk("bp_ready1", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // flush with both slots full and input offered
    out_ready = 1'b0;
    drive(64'hF1, 4'hF);
    drive(64'hF2, 4'hF);
    in_valid = 1'b1;
    payload_in = 64'hF3;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", ctrl_out, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) step();
    // flush discards a beat accepted in the same cycle
    in_valid = 1'b1;
    payload_in = 64'hF4;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2_valid", out_valid, 0);
    repeat (2) step();

    // bubble gating, counters restarted by a reset pulse
    rst_n = 1'b0;
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(64'h55, 4'b1001);
    in_valid = 1'b0;
    chk("bg_valid", out_valid, 1);
    chk("bg_ctrl_live", ctrl_out, 4'b1001);
    chk("bg_bub1", bubble_cnt, 1);
    step();
    chk("bg_gate", ctrl_out, 0);
    chk("bg_hold", payload_out, 64'h55);
    chk("bg_bub_e2", bubble_cnt, 1);
    step();
    chk("bg_bub_e3", bubble_cnt, 2);
    step();
    chk("bg_bub_e4", bubble_cnt, 3);
    chk("bg_hold2", payload_out, 64'h55);

    // stall counter saturation
    out_ready = 1'b0;
    drive(64'h77, 4'h8);
    in_valid = 1'b0;
    repeat (20) step();
    chk("sat15", stall_cnt, 15);
    step();
    chk("sat_hold", stall_cnt, 15);
    out_ready = 1'b1;
    repeat (2) step();

    // asynchronous reset with both slots full
    out_ready = 1'b0;
    drive(64'hC1, 4'hC);
    drive(64'hC2, 4'hC);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ctrl", ctrl_out, 0);
    chk("ar_payload", payload_out, 0);
    chk("ar_bub", bubble_cnt, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(64'hD0, 4'h2);
    in_valid = 1'b0;
    chk("first_acc", out_valid, 1);
    chk("first_acc_p", payload_out, 64'hD0);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      payload_in = {$urandom, $urandom};
      dest_in    = DW'($urandom);
      ctrl_in    = CW'($urandom);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
